// File: rtl/pio_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pio_wr_arbiter
//  Purpose  : Round-robin arbiter funnelling four byte-write requesters onto
//             one Avalon-MM 8-bit PIO slave. Optional readback check is
//             compiled in with macro PIO_ARB_READBACK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pio_wr_arbiter #(
  parameter int GAP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_src
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam bit         c_has_gap  = (GAP > 0);
  localparam logic [3:0] c_gap_load = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t      r_state;
  logic [1:0]  r_last;
  logic [1:0]  r_idx;
  logic [3:0]  r_gap_cnt;
  logic [3:0]  r_ack;
  logic        r_cs;
  logic        r_wn;
  logic        r_busy;
  logic [31:0] r_wd;
  logic        w_found;
  logic [1:0]  w_idx;
  logic [7:0]  w_byte;

`ifdef PIO_ARB_READBACK_EN
  logic [7:0]  r_byte;
  logic        r_err;
  logic [1:0]  r_err_src;
  logic        w_unused_rd;
  assign w_unused_rd = &{1'b0, avm_readdata[31:8]};
  assign err         = r_err;
  assign err_src     = r_err_src;
`else
  logic        w_unused_rd;
  assign w_unused_rd = &{1'b0, avm_readdata};
  assign err         = 1'b0;
  assign err_src     = 2'd0;
`endif

  // Search begins one past the last grant so a just-serviced requester goes last.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && req[r_last + 2'(k + 1)]) begin
        w_found = 1'b1;
        w_idx   = r_last + 2'(k + 1);
      end
    end
  end

  assign w_byte = req_data[8*w_idx +: 8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_last    <= 2'd3;
      r_idx     <= 2'd0;
      r_gap_cnt <= 4'd0;
      r_ack     <= 4'd0;
      r_cs      <= 1'b0;
      r_wn      <= 1'b1;
      r_busy    <= 1'b0;
      r_wd      <= 32'd0;
`ifdef PIO_ARB_READBACK_EN
      r_byte    <= 8'd0;
      r_err     <= 1'b0;
      r_err_src <= 2'd0;
`endif
    end else begin
      r_ack <= 4'd0;
      r_cs  <= 1'b0;
      r_wn  <= 1'b1;
      r_wd  <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_WRITE;
            r_busy  <= 1'b1;
            r_idx   <= w_idx;
            r_ack   <= 4'd1 << w_idx;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_wd    <= {24'd0, w_byte};
`ifdef PIO_ARB_READBACK_EN
            r_byte  <= w_byte;
`endif
          end
        end
        S_WRITE: begin
          r_last <= r_idx;
`ifdef PIO_ARB_READBACK_EN
          r_state <= S_READ;
          r_cs    <= 1'b1;
`else
          if (c_has_gap) begin
            r_state   <= S_GAP;
            r_gap_cnt <= c_gap_load;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
`endif
        end
`ifdef PIO_ARB_READBACK_EN
        S_READ: begin
          // Slave returns data combinationally; compare against the byte written.
          if (avm_readdata[7:0] != r_byte && !r_err) begin
            r_err     <= 1'b1;
            r_err_src <= r_idx;
          end
          if (c_has_gap) begin
            r_state   <= S_GAP;
            r_gap_cnt <= c_gap_load;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
        S_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack            = r_ack;
  assign avm_address    = 2'd0;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_writedata  = r_wd;
  assign busy           = r_busy;

endmodule
`default_nettype wire
